// File: rtl/fsm_ras_pkg.sv
// fsm_ras_pkg: shared constants and types for the chooser table and return-address stack
package fsm_ras_pkg;
  localparam int TBL_IDX_W_DEF = 10;
  localparam int RAS_DEPTH_DEF = 16;
  localparam logic [5:0] JR_OPCODE = 6'h00;
  localparam logic [5:0] JR_FUNCT = 6'h08;
  localparam logic [4:0] JR_RS = 5'd31;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_INIT = 2'b01;
endpackage

// File: rtl/meta_chooser.sv
// meta_chooser: table of 2-bit saturating counters selecting global vs local prediction
module meta_chooser
  import fsm_ras_pkg::*;
#(
  parameter int TBL_IDX_W = TBL_IDX_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      isTaken,
  input  logic                      isBranch,
  input  logic [31:0]               InstrPC,
  output logic [2**TBL_IDX_W-1:0]   Pred
);
  localparam int N = 2**TBL_IDX_W;
  ctr_t ctr [N];
  ctr_t cur;
  logic [TBL_IDX_W-1:0] idx;
  logic unused_pc;
  assign idx = InstrPC[TBL_IDX_W+1:2];
  assign cur = ctr[idx];
  assign unused_pc = ^{InstrPC[31:TBL_IDX_W+2], InstrPC[1:0]};
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) ctr[i] <= CTR_INIT;
    end else if (isBranch) begin
      ctr[idx] <= isTaken ? (cur == 2'd3 ? cur : cur + 2'd1) : (cur == 2'd0 ? cur : cur - 2'd1);
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_pred
    assign Pred[g] = ctr[g][1];
  end
endmodule

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack predicting JR $ra targets in IF
module ret_addr_stack
  import fsm_ras_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] InstrPC_IF,
  input  logic [31:0] Instr_IF,
  input  logic        IsJL,
  input  logic [31:0] InstrPC_ID,
  output logic        hit,
  output logic [31:0] alt_PC
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [31:0] stack [RAS_DEPTH];
  logic [PW-1:0] top;
  logic [CW-1:0] cnt;
  logic is_ret;
  logic [31:0] push_addr;
  logic unused_if;
  assign is_ret = Instr_IF[31:26] == JR_OPCODE && Instr_IF[25:21] == JR_RS && Instr_IF[5:0] == JR_FUNCT;
  assign hit = is_ret && cnt != '0;
  assign alt_PC = hit ? stack[top] : '0;
  assign push_addr = InstrPC_ID + 32'd8;
  assign unused_if = ^{InstrPC_IF, Instr_IF[20:6]};
  // top always points at the live entry; a full push simply overwrites the oldest slot
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      top <= '0;
      cnt <= '0;
    end else if (IsJL && hit) begin
      stack[top] <= push_addr;
    end else if (IsJL) begin
      stack[top + PW'(1)] <= push_addr;
      top <= top + PW'(1);
      cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + CW'(1);
    end else if (hit) begin
      top <= top - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/fsm_ras.sv
// fsm_ras: tournament chooser table plus return-address stack
module fsm_ras
  import fsm_ras_pkg::*;
#(
  parameter int TBL_IDX_W = TBL_IDX_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    isTaken,
  input  logic                    isBranch,
  input  logic [31:0]             InstrPC,
  output logic [2**TBL_IDX_W-1:0] Pred,
  input  logic [31:0]             InstrPC_IF,
  input  logic [31:0]             Instr_IF,
  input  logic                    IsJL,
  input  logic [31:0]             InstrPC_ID,
  output logic                    hit,
  output logic [31:0]             alt_PC
);
  meta_chooser #(.TBL_IDX_W(TBL_IDX_W)) u_chooser (
    .CLK(CLK), .RESET(RESET), .isTaken(isTaken), .isBranch(isBranch),
    .InstrPC(InstrPC), .Pred(Pred)
  );
  ret_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .CLK(CLK), .RESET(RESET), .InstrPC_IF(InstrPC_IF), .Instr_IF(Instr_IF),
    .IsJL(IsJL), .InstrPC_ID(InstrPC_ID), .hit(hit), .alt_PC(alt_PC)
  );
endmodule

// File: tb/tb_fsm_ras.sv
// tb_fsm_ras: randomized and directed checks against a queue/array reference model
module tb_fsm_ras;
  localparam logic [31:0] JR_RA = 32'h03E0_0008;
  logic CLK = 0;
  logic RESET = 1, isTaken = 0, isBranch = 0, IsJL = 0, hit;
  logic [31:0] InstrPC = 0, InstrPC_IF = 0, Instr_IF = 0, InstrPC_ID = 0, alt_PC;
  logic [1023:0] Pred;
  int checks = 0, errors = 0;
  int ctr [1024];
  logic [31:0] q[$];

  always #5 CLK = ~CLK;

  fsm_ras dut (
    .CLK(CLK), .RESET(RESET), .isTaken(isTaken), .isBranch(isBranch), .InstrPC(InstrPC),
    .Pred(Pred), .InstrPC_IF(InstrPC_IF), .Instr_IF(Instr_IF), .IsJL(IsJL),
    .InstrPC_ID(InstrPC_ID), .hit(hit), .alt_PC(alt_PC)
  );

  function automatic logic is_ret(logic [31:0] i);
    return i[31:26] == 6'h00 && i[25:21] == 5'd31 && i[5:0] == 6'h08;
  endfunction

  function automatic logic [1023:0] exp_pred();
    logic [1023:0] p;
    for (int i = 0; i < 1024; i++) p[i] = ctr[i] >= 2;
    return p;
  endfunction

  function automatic int first_diff(logic [1023:0] a, logic [1023:0] b);
    for (int i = 0; i < 1024; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic exp_hit();
    return is_ret(Instr_IF) && q.size() > 0;
  endfunction

  function automatic logic [31:0] exp_alt();
    return exp_hit() ? q[q.size()-1] : 32'h0;
  endfunction

  task automatic step();
    int k;
    logic h;
    if (RESET) begin
      foreach (ctr[i]) ctr[i] = 1;
      q.delete();
    end else begin
      k = int'(InstrPC[11:2]);
      if (isBranch && isTaken && ctr[k] < 3) ctr[k]++;
      else if (isBranch && !isTaken && ctr[k] > 0) ctr[k]--;
      h = exp_hit();
      if (IsJL && h) q[q.size()-1] = InstrPC_ID + 32'd8;
      else if (IsJL) begin
        q.push_back(InstrPC_ID + 32'd8);
        if (q.size() > 16) void'(q.pop_front());
      end else if (h) void'(q.pop_back());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 0; isBranch = 0; isTaken = 0; IsJL = 0; Instr_IF = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    step();
    idle();
    Instr_IF = JR_RA;
    #1;
    checks++;
    if (Pred !== '0) begin errors++; $display("FAIL reset_pred idx %0d", first_diff(Pred, '0)); end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit act %b exp 0", hit); end
    checks++;
    if (alt_PC !== 32'h0) begin errors++; $display("FAIL reset_alt act %h exp 0", alt_PC); end
    idle();
  endtask

  task automatic test_chooser();
    idle();
    InstrPC = 32'h0000_0404; isBranch = 1; isTaken = 1;
    step();
    isBranch = 0;
    #1;
    checks++;
    if (Pred[257] !== 1'b1) begin errors++; $display("FAIL chooser_first act %b exp 1", Pred[257]); end
    isBranch = 1;
    repeat (5) step();
    isTaken = 0;
    step();
    isBranch = 0;
    #1;
    checks++;
    if (Pred[257] !== 1'b1) begin errors++; $display("FAIL chooser_sat act %b exp 1", Pred[257]); end
    isBranch = 1;
    repeat (2) step();
    isBranch = 0;
    #1;
    checks++;
    if (Pred[257] !== 1'b0) begin errors++; $display("FAIL chooser_down act %b exp 0", Pred[257]); end
    checks++;
    if (Pred !== exp_pred()) begin errors++; $display("FAIL chooser_vec idx %0d", first_diff(Pred, exp_pred())); end
    InstrPC = 32'h0000_0408; isBranch = 0; isTaken = 1;
    repeat (3) step();
    checks++;
    if (Pred[258] !== 1'b0) begin errors++; $display("FAIL chooser_noupd act %b exp 0", Pred[258]); end
  endtask

  task automatic test_ras_single();
    idle();
    IsJL = 1; InstrPC_ID = 32'h0040_0100;
    step();
    IsJL = 0; Instr_IF = JR_RA;
    #1;
    checks++;
    if (hit !== 1'b1 || alt_PC !== 32'h0040_0108) begin
      errors++; $display("FAIL ras_single hit %b alt %h exp 1 00400108", hit, alt_PC);
    end
    step();
    checks++;
    if (hit !== 1'b0 || alt_PC !== 32'h0) begin
      errors++; $display("FAIL ras_empty hit %b alt %h exp 0 0", hit, alt_PC);
    end
    idle();
  endtask

  task automatic test_ras_lifo();
    logic [31:0] exp [3];
    exp = '{32'h300, 32'h200, 32'h100};
    idle();
    IsJL = 1;
    InstrPC_ID = 32'hF8;  step();
    InstrPC_ID = 32'h1F8; step();
    InstrPC_ID = 32'h2F8; step();
    IsJL = 0; Instr_IF = JR_RA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (hit !== 1'b1 || alt_PC !== exp[i]) begin
        errors++; $display("FAIL ras_lifo%0d hit %b alt %h exp 1 %h", i, hit, alt_PC, exp[i]);
      end
      step();
    end
    idle();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] base;
    base = $urandom & 32'hFFFF_FFF0;
    idle();
    IsJL = 1;
    for (int i = 0; i < 17; i++) begin
      InstrPC_ID = base + 32'(i * 4);
      step();
    end
    IsJL = 0; Instr_IF = JR_RA;
    for (int j = 0; j < 16; j++) begin
      #1;
      checks++;
      if (hit !== 1'b1 || alt_PC !== base + 32'((16 - j) * 4 + 8)) begin
        errors++; $display("FAIL ras_ovf%0d hit %b alt %h exp 1 %h", j, hit, alt_PC, base + 32'((16 - j) * 4 + 8));
      end
      step();
    end
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL ras_ovf_empty hit %b exp 0", hit); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    IsJL = 1; InstrPC_ID = 32'hF8;
    step();
    InstrPC_ID = 32'h500; Instr_IF = JR_RA;
    #1;
    checks++;
    if (hit !== 1'b1 || alt_PC !== 32'h100) begin
      errors++; $display("FAIL b2b_same hit %b alt %h exp 1 00000100", hit, alt_PC);
    end
    step();
    IsJL = 0;
    #1;
    checks++;
    if (hit !== 1'b1 || alt_PC !== 32'h508) begin
      errors++; $display("FAIL b2b_next hit %b alt %h exp 1 00000508", hit, alt_PC);
    end
    step();
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL b2b_empty hit %b exp 0", hit); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      RESET = $urandom_range(0, 79) == 0;
      isBranch = $urandom_range(0, 1);
      isTaken = $urandom_range(0, 1);
      InstrPC = {$urandom} & 32'h0000_0FFC;
      if ($urandom_range(0, 1)) InstrPC = 32'(($urandom_range(0, 3)) << 2);
      IsJL = $urandom_range(0, 2) == 0;
      InstrPC_ID = $urandom;
      InstrPC_IF = $urandom;
      case ($urandom_range(0, 3))
        0: Instr_IF = JR_RA;
        1: Instr_IF = JR_RA | ({$urandom} & 32'h001F_FFC0);
        2: Instr_IF = 32'h0100_0008;
        default: Instr_IF = $urandom;
      endcase
      #1;
      checks++;
      if (hit !== exp_hit() || alt_PC !== exp_alt()) begin
        errors++; $display("FAIL rnd_ras%0d hit %b alt %h exp %b %h", n, hit, alt_PC, exp_hit(), exp_alt());
      end
      step();
      checks++;
      if (Pred !== exp_pred()) begin
        errors++; $display("FAIL rnd_pred%0d idx %0d", n, first_diff(Pred, exp_pred()));
      end
    end
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    IsJL = 1; InstrPC_ID = 32'h700;
    step();
    RESET = 1; IsJL = 1; InstrPC_ID = 32'h800; Instr_IF = JR_RA;
    isBranch = 1; isTaken = 1; InstrPC = 32'h0000_0404;
    step();
    idle();
    Instr_IF = JR_RA;
    #1;
    checks++;
    if (hit !== 1'b0 || alt_PC !== 32'h0) begin
      errors++; $display("FAIL rst_prio_ras hit %b alt %h exp 0 0", hit, alt_PC);
    end
    checks++;
    if (Pred !== '0) begin errors++; $display("FAIL rst_prio_pred idx %0d", first_diff(Pred, '0)); end
    idle();
  endtask

  initial begin
    test_reset();
    test_chooser();
    test_ras_single();
    test_ras_lifo();
    test_ras_overflow();
    test_back_to_back();
    test_random();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
